// File: rtl/spi_pkg.sv
// Shared types and constants for the FIFO-fed SPI master slice.
package spi_pkg;

    localparam int SPI_BYTE_BITS = 8;
    localparam int SPI_DIV_W     = 8;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT_LO,
        SHIFT_HI,
        CS_HOLD,
        CS_GAP
    } spi_state_t;

endpackage

// File: rtl/spi_fifo_master_if.sv
// Bundle of FIFO-side, SPI-pin and readback signals of spi_fifo_master.
// master = the SPI engine, slave = the surrounding fabric / pads.
interface spi_fifo_master_if;
    import spi_pkg::*;

    logic [SPI_BYTE_BITS-1:0] fifo_data;
    logic                     fifo_last;
    logic                     fifo_empty;
    logic                     fifo_rden;
    logic                     spi_sck;
    logic                     spi_mosi;
    logic                     spi_miso;
    logic                     spi_cs_n;
    logic [SPI_BYTE_BITS-1:0] rd_data;
    logic                     rd_valid;
    logic                     busy;

    modport master (
        input  fifo_data, fifo_last, fifo_empty, spi_miso,
        output fifo_rden, spi_sck, spi_mosi, spi_cs_n, rd_data, rd_valid, busy
    );

    modport slave (
        output fifo_data, fifo_last, fifo_empty, spi_miso,
        input  fifo_rden, spi_sck, spi_mosi, spi_cs_n, rd_data, rd_valid, busy
    );

endinterface

// File: rtl/spi_fifo_master_clk_div.sv
// spi_clk_div: loadable down-counter; tick_o is high while the count sits at zero.
// Loading N gives a tick after N+1 cycles, so callers load (cycles - 1).
module spi_clk_div
    import spi_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load_i,
    input  logic [SPI_DIV_W-1:0] load_val_i,
    output logic                 tick_o
);

    logic [SPI_DIV_W-1:0] cnt_q, cnt_d;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignment so all flops update together.
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = (cnt_q == '0);

endmodule

// File: rtl/spi_fifo_master.sv
// spi_fifo_master: pops bytes from a FWFT FIFO and shifts them out MSB-first on mode-0 SPI,
// holding CS low per packet. Define SPI_FIFO_MASTER_READBACK_EN to return MISO bytes on rd_data.
module spi_fifo_master
    import spi_pkg::*;
#(
    parameter int DIV = 2,
    parameter int GAP = 2
) (
    input logic               clk,
    input logic               rst_n,
    spi_fifo_master_if.master bus
);

    localparam logic [2:0]           BIT_LAST = 3'(SPI_BYTE_BITS - 1);
    localparam logic [SPI_DIV_W-1:0] DIV_LOAD = SPI_DIV_W'(DIV - 1);
    localparam logic [SPI_DIV_W-1:0] GAP_LOAD = SPI_DIV_W'(GAP - 1);

    spi_state_t               state_q, state_d;
    logic [SPI_BYTE_BITS-1:0] shreg_q, shreg_d;
    logic [2:0]               bitcnt_q, bitcnt_d;
    logic                     last_q, last_d;
    logic                     stall_q, stall_d;
    logic                     pop, reload, tick, div_load;
    logic [SPI_DIV_W-1:0]     div_val;
    logic                     sck_q, cs_n_q, mosi_q, busy_q;

    spi_clk_div u_clk_div (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (div_load),
        .load_val_i (div_val),
        .tick_o     (tick)
    );

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;
        last_d   = last_q;
        stall_d  = stall_q;
        pop      = 1'b0;
        reload   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!bus.fifo_empty) begin
                    pop     = 1'b1;
                    state_d = SHIFT_LO;
                end
            end
            SHIFT_LO: begin
                // Underrun stall reuses SHIFT_LO with SCK parked low until data arrives.
                if (stall_q) begin
                    if (!bus.fifo_empty) begin
                        pop    = 1'b1;
                        reload = 1'b1;
                    end
                end else if (tick) begin
                    state_d = SHIFT_HI;
                end
            end
            SHIFT_HI: begin
                if (tick) begin
                    shreg_d = {shreg_q[SPI_BYTE_BITS-2:0], 1'b0};
                    if (bitcnt_q != BIT_LAST) begin
                        bitcnt_d = bitcnt_q + 3'd1;
                        state_d  = SHIFT_LO;
                    end else if (last_q) begin
                        state_d = CS_HOLD;
                    end else begin
                        state_d = SHIFT_LO;
                        if (!bus.fifo_empty) begin
                            pop = 1'b1;
                        end else begin
                            stall_d = 1'b1;
                        end
                    end
                end
            end
            CS_HOLD: if (tick) state_d = CS_GAP;
            CS_GAP:  if (tick) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (pop) begin
            shreg_d  = bus.fifo_data;
            last_d   = bus.fifo_last;
            bitcnt_d = '0;
            stall_d  = 1'b0;
        end
    end

    assign div_load = (state_d != state_q) || reload;
    assign div_val  = (state_d == CS_GAP) ? GAP_LOAD : DIV_LOAD;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            shreg_q  <= '0;
            bitcnt_q <= '0;
            last_q   <= 1'b0;
            stall_q  <= 1'b0;
            sck_q    <= 1'b0;
            cs_n_q   <= 1'b1;
            mosi_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            bitcnt_q <= bitcnt_d;
            last_q   <= last_d;
            stall_q  <= stall_d;
            sck_q    <= (state_d == SHIFT_HI);
            cs_n_q   <= (state_d == IDLE) || (state_d == CS_GAP);
            mosi_q   <= ((state_d == SHIFT_LO) || (state_d == SHIFT_HI)) ? shreg_d[SPI_BYTE_BITS-1] : 1'b0;
            busy_q   <= (state_d != IDLE);
        end
    end

    // The pop strobe is combinational, so it must also be forced low while reset is held.
    assign bus.fifo_rden = pop & rst_n;
    assign bus.spi_sck   = sck_q;
    assign bus.spi_cs_n  = cs_n_q;
    assign bus.spi_mosi  = mosi_q;
    assign bus.busy      = busy_q;

`ifdef SPI_FIFO_MASTER_READBACK_EN
    logic [SPI_BYTE_BITS-1:0] rx_q;
    logic [SPI_BYTE_BITS-1:0] rd_data_q;
    logic                     rd_valid_q;
    logic                     sck_rise, byte_done;

    assign sck_rise  = (state_q == SHIFT_LO) && (state_d == SHIFT_HI);
    assign byte_done = (state_q == SHIFT_HI) && tick && (bitcnt_q == BIT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_q       <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            if (sck_rise) begin
                rx_q <= {rx_q[SPI_BYTE_BITS-2:0], bus.spi_miso};
            end
            rd_valid_q <= byte_done;
            if (byte_done) begin
                rd_data_q <= rx_q;
            end
        end
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
`else
    logic unused_miso;
    assign unused_miso  = bus.spi_miso;
    assign bus.rd_data  = '0;
    assign bus.rd_valid = 1'b0;
`endif

endmodule

// File: tb/tb_spi_fifo_master.sv
// Self-checking bench for spi_fifo_master: a cycle-timeline model derived from byte/phase
// arithmetic is compared against the DUT every cycle, plus literal checks per directed scenario.
module tb_spi_fifo_master;

    localparam int DIV      = 2;
    localparam int GAP      = 2;
    localparam int BYTE_CYC = 16 * DIV;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spi_fifo_master_if bus ();

    spi_fifo_master #(.DIV(DIV), .GAP(GAP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    assign bus.spi_miso = bus.spi_mosi;

    int n_checks = 0;
    int n_pass   = 0;

    logic [8:0] fifo_q[$];

    typedef enum {PH_IDLE, PH_BYTE, PH_STALL, PH_HOLD, PH_GAP} phase_t;
    phase_t     m_phase;
    int         m_t;
    int         m_cnt;
    logic [7:0] m_byte;
    logic       m_last;
    logic       m_rdv;
    logic [7:0] m_rdd;

    int         sck_rises, cs_low_cyc, cs_falls, pops, gap_run, min_gap, rdv_cnt, rdv_total;
    logic       seen_fall, prev_sck, prev_cs;
    logic [7:0] mosi_bits;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic drive_fifo();
        bus.fifo_empty = (fifo_q.size() == 0);
        if (fifo_q.size() != 0) begin
            bus.fifo_data = fifo_q[0][7:0];
            bus.fifo_last = fifo_q[0][8];
        end else begin
            bus.fifo_data = 8'($urandom);
            bus.fifo_last = 1'($urandom);
        end
    endtask

    task automatic push(input logic [7:0] d, input logic l);
        fifo_q.push_back({l, d});
        drive_fifo();
    endtask

    task automatic model_reset();
        m_phase = PH_IDLE;
        m_t     = 0;
        m_cnt   = 0;
        m_rdv   = 1'b0;
        m_rdd   = 8'h00;
    endtask

    task automatic clear_mon();
        sck_rises  = 0;
        cs_low_cyc = 0;
        cs_falls   = 0;
        pops       = 0;
        gap_run    = 0;
        min_gap    = 1000;
        rdv_cnt    = 0;
        seen_fall  = 1'b0;
        mosi_bits  = 8'h00;
    endtask

    // One clock cycle: compare at the falling edge, then advance model and FIFO after the rise.
    task automatic step();
        logic e_cs, e_sck, e_busy, e_rden, nonempty, dut_pop;
        @(negedge clk);
        nonempty = (fifo_q.size() != 0);
        e_cs = 1'b1; e_sck = 1'b0; e_busy = 1'b1; e_rden = 1'b0;
        case (m_phase)
            PH_IDLE:  begin e_busy = 1'b0; e_rden = nonempty; end
            PH_BYTE:  begin
                e_cs   = 1'b0;
                e_sck  = 1'((m_t / DIV) % 2);
                e_rden = (m_t == BYTE_CYC - 1) && !m_last && nonempty;
                check("mosi", bus.spi_mosi, m_byte[7 - m_t / (2 * DIV)]);
            end
            PH_STALL: begin e_cs = 1'b0; e_rden = nonempty; end
            PH_HOLD:  e_cs = 1'b0;
            default:  e_cs = 1'b1;
        endcase
        check("cs_n", bus.spi_cs_n, e_cs);
        check("sck", bus.spi_sck, e_sck);
        check("busy", bus.busy, e_busy);
        check("rden", bus.fifo_rden, e_rden);
`ifdef SPI_FIFO_MASTER_READBACK_EN
        check("rd_valid", bus.rd_valid, m_rdv);
        check("rd_data", bus.rd_data, m_rdd);
`else
        check("rd_valid_off", bus.rd_valid, 1'b0);
        check("rd_data_off", bus.rd_data, 8'h00);
`endif
        if (!prev_sck && bus.spi_sck) begin
            sck_rises++;
            mosi_bits = {mosi_bits[6:0], bus.spi_mosi};
        end
        if (!bus.spi_cs_n) cs_low_cyc++;
        if (prev_cs && !bus.spi_cs_n) begin
            cs_falls++;
            if (seen_fall && gap_run < min_gap) min_gap = gap_run;
            seen_fall = 1'b1;
        end
        gap_run = bus.spi_cs_n ? gap_run + 1 : 0;
        if (bus.fifo_rden) pops++;
        if (bus.rd_valid) begin rdv_cnt++; rdv_total++; end
        prev_sck = bus.spi_sck;
        prev_cs  = bus.spi_cs_n;
        dut_pop  = bus.fifo_rden;

        @(posedge clk);
        #1;
        m_rdv = 1'b0;
        case (m_phase)
            PH_IDLE, PH_STALL: begin
                if (e_rden) begin
                    m_byte = fifo_q[0][7:0]; m_last = fifo_q[0][8]; m_t = 0; m_phase = PH_BYTE;
                end
            end
            PH_BYTE: begin
                if (m_t == BYTE_CYC - 1) begin
                    m_rdv = 1'b1;
                    m_rdd = m_byte;
                    if (m_last) begin
                        m_phase = PH_HOLD; m_cnt = 0;
                    end else if (e_rden) begin
                        m_byte = fifo_q[0][7:0]; m_last = fifo_q[0][8]; m_t = 0;
                    end else begin
                        m_phase = PH_STALL;
                    end
                end else begin
                    m_t++;
                end
            end
            PH_HOLD: begin
                if (m_cnt == DIV - 1) begin m_phase = PH_GAP; m_cnt = 0; end
                else m_cnt++;
            end
            default: begin
                if (m_cnt == GAP - 1) m_phase = PH_IDLE;
                else m_cnt++;
            end
        endcase
        if (dut_pop && fifo_q.size() != 0) void'(fifo_q.pop_front());
        drive_fifo();
    endtask

    task automatic run_until_idle(input int limit);
        int n = 0;
        do begin
            step();
            n++;
        end while (!(m_phase == PH_IDLE && fifo_q.size() == 0) && n < limit);
        check("reach_idle", (m_phase == PH_IDLE), 1'b1);
        step();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cs_n"}, bus.spi_cs_n, 1'b1);
        check({tag, "_sck"}, bus.spi_sck, 1'b0);
        check({tag, "_mosi"}, bus.spi_mosi, 1'b0);
        check({tag, "_busy"}, bus.busy, 1'b0);
        check({tag, "_rden"}, bus.fifo_rden, 1'b0);
        check({tag, "_rd_data"}, bus.rd_data, 8'h00);
        check({tag, "_rd_valid"}, bus.rd_valid, 1'b0);
    endtask

    initial begin
        int n;
        rdv_total = 0;
        prev_sck  = 1'b0;
        prev_cs   = 1'b1;
        model_reset();
        clear_mon();
        drive_fifo();

        // Reset state, with a byte already waiting so the pop strobe must be suppressed.
        #12;
        push(8'hA5, 1'b1);
        #1;
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single byte A5 with last.
        clear_mon();
        run_until_idle(200);
        check("a5_rises", sck_rises, 8);
        check("a5_mosi_bits", mosi_bits, 8'hA5);
        check("a5_cs_low", cs_low_cyc, 17 * DIV);
        check("a5_pops", pops, 1);
        check("a5_cs_windows", cs_falls, 1);

        // Three-byte packet preloaded: one contiguous CS window.
        clear_mon();
        push(8'h01, 1'b0);
        push(8'h02, 1'b0);
        push(8'hFF, 1'b1);
        run_until_idle(400);
        check("pkt3_rises", sck_rises, 24);
        check("pkt3_cs_low", cs_low_cyc, 3 * BYTE_CYC + DIV);
        check("pkt3_pops", pops, 3);
        check("pkt3_cs_windows", cs_falls, 1);

        // Underrun: the second byte arrives after the first has finished shifting.
        clear_mon();
        push(8'h10, 1'b0);
        repeat (BYTE_CYC + 8) step();
        check("underrun_stalled", (m_phase == PH_STALL), 1'b1);
        push(8'h20, 1'b1);
        run_until_idle(400);
        check("underrun_rises", sck_rises, 16);
        check("underrun_cs_windows", cs_falls, 1);
        check("underrun_pops", pops, 2);

        // Two one-byte packets back to back.
        clear_mon();
        push(8'h55, 1'b1);
        push(8'hAA, 1'b1);
        run_until_idle(400);
        check("two_pkt_windows", cs_falls, 2);
        check("two_pkt_gap_ok", (min_gap >= GAP), 1'b1);

        // Reset asserted at the 5th SCK rise of a byte.
        push(8'hC3, 1'b0);
        push(8'h5A, 1'b1);
        n = 0;
        while (!(m_phase == PH_BYTE && m_t == 9 * DIV) && n < 200) begin
            step();
            n++;
        end
        check("mid_byte_reached", (m_phase == PH_BYTE && m_t == 9 * DIV), 1'b1);
        check("mid_byte_sck_high", bus.spi_sck, 1'b1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("held_reset");
        model_reset();
        prev_sck = 1'b0;
        prev_cs  = 1'b1;
        clear_mon();
        rst_n = 1'b1;
        run_until_idle(200);
        check("after_reset_windows", cs_falls, 1);
        check("after_reset_rises", sck_rises, 8);
        check("after_reset_mosi_bits", mosi_bits, 8'h5A);

        // Loopback byte 3C.
        clear_mon();
        push(8'h3C, 1'b1);
        run_until_idle(200);
`ifdef SPI_FIFO_MASTER_READBACK_EN
        check("rb_pulses", rdv_cnt, 1);
        check("rb_data", bus.rd_data, 8'h3C);
`else
        check("rb_off_pulses", rdv_cnt, 0);
`endif

        // Randomized packets with random push timing (underruns arise naturally).
        for (int p = 0; p < 30; p++) begin
            int len;
            len = int'($urandom_range(1, 4));
            for (int b = 0; b < len; b++) begin
                push(8'($urandom), (b == len - 1));
                repeat ($urandom_range(0, 45)) step();
            end
            if ($urandom_range(0, 2) == 0) run_until_idle(1000);
        end
        run_until_idle(2000);

`ifndef SPI_FIFO_MASTER_READBACK_EN
        check("rd_valid_never", rdv_total, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
